rle_token_mux: RTL and testbench

- Parametrised successor to the RLE output select mux.
- Accepts run records (data word plus run count) over a valid/ready handshake and serialises each run into tokens on a single output stream. A token is either a count word (count zero-extended to DATA_W) or a data word.
- Adds a compact mode, zero-count drop detection, backpressure and a saturating token counter.
- Sits between the RLE run detector and the output word packer.

---
 rtl/rle_token_mux.sv | 120 ++++++++++++
 tb/tb_rle_token_mux.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rle_token_mux.sv
`default_nettype none
// ============================================================================
//  Module   : rle_token_mux
//  Brief    : Serialises RLE run records into count/data tokens with optional
//             compact mode, zero-count drop pulse and saturating token count.
//  Revision : 1.0
// ============================================================================
module rle_token_mux #(
    parameter int DATA_W  = 32,
    parameter int COUNT_W = 8,
    parameter int STAT_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mode,
    input  logic               run_valid,
    input  logic [DATA_W-1:0]  run_data,
    input  logic [COUNT_W-1:0] run_count,
    output logic               run_ready,
    output logic               tok_valid,
    output logic [DATA_W-1:0]  tok_data,
    output logic               tok_is_count,
    input  logic               tok_ready,
    output logic               run_drop,
    output logic [STAT_W-1:0]  tok_total
);

    generate
        if (COUNT_W > DATA_W) begin : g_bad_count_width
            $error("rle_token_mux: COUNT_W must not exceed DATA_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT_CNT  = 2'd1,
        EMIT_DATA = 2'd2
    } state_t;

    localparam logic [STAT_W-1:0] C_TOTAL_MAX = {STAT_W{1'b1}};

    state_t               r_state_q,      w_state_d;
    logic [DATA_W-1:0]    r_hold_data_q,  w_hold_data_d;
    logic [COUNT_W-1:0]   r_hold_count_q, w_hold_count_d;
    logic                 r_run_drop_q,   w_run_drop_d;
    logic [STAT_W-1:0]    r_tok_total_q,  w_tok_total_d;

    logic                 w_run_ready;
    logic                 w_run_accept;
    logic                 w_tok_valid;
    logic                 w_tok_hs;
    logic [DATA_W-1:0]    w_count_ext;

    // Only EMIT_DATA lets tok_ready reach run_ready, enabling back-to-back runs.
    assign w_run_ready  = !reset && ((r_state_q == IDLE) ||
                                     ((r_state_q == EMIT_DATA) && tok_ready));
    assign w_run_accept = run_valid && w_run_ready;
    assign w_tok_valid  = !reset && (r_state_q != IDLE);
    assign w_tok_hs     = w_tok_valid && tok_ready;
    assign w_count_ext  = DATA_W'(r_hold_count_q);

    always_comb begin
        w_state_d      = r_state_q;
        w_hold_data_d  = r_hold_data_q;
        w_hold_count_d = r_hold_count_q;
        w_run_drop_d   = 1'b0;
        w_tok_total_d  = r_tok_total_q;

        case (r_state_q)
            IDLE:      w_state_d = IDLE;
            EMIT_CNT:  if (tok_ready) w_state_d = EMIT_DATA;
            EMIT_DATA: if (tok_ready) w_state_d = IDLE;
            default:   w_state_d = IDLE;
        endcase

        // Acceptance overrides the drain-to-IDLE decision above.
        if (w_run_accept) begin
            w_hold_data_d  = run_data;
            w_hold_count_d = run_count;
            if (run_count == '0) begin
                w_state_d    = IDLE;
                w_run_drop_d = 1'b1;
            end else if (mode && (run_count == COUNT_W'(1))) begin
                w_state_d = EMIT_DATA;
            end else begin
                w_state_d = EMIT_CNT;
            end
        end

        if (w_tok_hs && (r_tok_total_q != C_TOTAL_MAX)) begin
            w_tok_total_d = r_tok_total_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q      <= IDLE;
            r_hold_data_q  <= '0;
            r_hold_count_q <= '0;
            r_run_drop_q   <= 1'b0;
            r_tok_total_q  <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_hold_data_q  <= w_hold_data_d;
            r_hold_count_q <= w_hold_count_d;
            r_run_drop_q   <= w_run_drop_d;
            r_tok_total_q  <= w_tok_total_d;
        end
    end

    assign run_ready    = w_run_ready;
    assign tok_valid    = w_tok_valid;
    assign tok_is_count = (r_state_q == EMIT_CNT);
    assign tok_data     = (r_state_q == EMIT_CNT)  ? w_count_ext   :
                          (r_state_q == EMIT_DATA) ? r_hold_data_q : '0;
    assign run_drop     = r_run_drop_q;
    assign tok_total    = r_tok_total_q;

endmodule
`default_nettype wire

// File: tb/tb_rle_token_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rle_token_mux
//  Brief    : Directed plus randomized bench for rle_token_mux against a
//             token-queue reference model.
//  Revision : 1.0
// ============================================================================
module tb_rle_token_mux;

    localparam int DATA_W  = 32;
    localparam int COUNT_W = 8;
    localparam int STAT_W  = 16;
    localparam int SAT_W   = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               mode = 1'b0;
    logic               run_valid = 1'b0;
    logic [DATA_W-1:0]  run_data = '0;
    logic [COUNT_W-1:0] run_count = '0;
    logic               tok_ready = 1'b0;

    logic               run_ready, tok_valid, tok_is_count, run_drop;
    logic [DATA_W-1:0]  tok_data;
    logic [STAT_W-1:0]  tok_total;

    logic               s_run_ready, s_tok_valid, s_tok_is_count, s_run_drop;
    logic [DATA_W-1:0]  s_tok_data;
    logic [SAT_W-1:0]   s_tok_total;

    rle_token_mux #(.DATA_W(DATA_W), .COUNT_W(COUNT_W), .STAT_W(STAT_W)) dut (
        .clock(clock), .reset(reset), .mode(mode),
        .run_valid(run_valid), .run_data(run_data), .run_count(run_count),
        .run_ready(run_ready), .tok_valid(tok_valid), .tok_data(tok_data),
        .tok_is_count(tok_is_count), .tok_ready(tok_ready),
        .run_drop(run_drop), .tok_total(tok_total)
    );

    rle_token_mux #(.DATA_W(DATA_W), .COUNT_W(COUNT_W), .STAT_W(SAT_W)) dut_sat (
        .clock(clock), .reset(reset), .mode(mode),
        .run_valid(run_valid), .run_data(run_data), .run_count(run_count),
        .run_ready(s_run_ready), .tok_valid(s_tok_valid), .tok_data(s_tok_data),
        .tok_is_count(s_tok_is_count), .tok_ready(tok_ready),
        .run_drop(s_run_drop), .tok_total(s_tok_total)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              c;
    } tok_t;

    tok_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_total = 0;
    bit   m_drop  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance the model.
    task automatic step(input bit rv, input logic [DATA_W-1:0] rd,
                        input logic [COUNT_W-1:0] rc, input bit md, input bit tr);
        bit   exp_ready, exp_valid, acc, hs;
        tok_t f;
        int   cap16, cap2;
        run_valid = rv; run_data = rd; run_count = rc; mode = md; tok_ready = tr;
        @(negedge clock);
        exp_valid = (q.size() > 0);
        f         = exp_valid ? q[0] : '0;
        exp_ready = (q.size() == 0) || (q.size() == 1 && !q[0].c && tr);
        cap16     = (m_total > 65535) ? 65535 : m_total;
        cap2      = (m_total > 3) ? 3 : m_total;
        chk("run_ready",    64'(run_ready),    64'(exp_ready));
        chk("tok_valid",    64'(tok_valid),    64'(exp_valid));
        chk("tok_data",     64'(tok_data),     64'(f.d));
        chk("tok_is_count", 64'(tok_is_count), 64'(f.c));
        chk("run_drop",     64'(run_drop),     64'(m_drop));
        chk("tok_total",    64'(tok_total),    64'(cap16));
        chk("sat_total",    64'(s_tok_total),  64'(cap2));
        acc    = rv && exp_ready;
        hs     = exp_valid && tr;
        m_drop = acc && (rc == 0);
        if (hs) begin
            void'(q.pop_front());
            m_total++;
        end
        if (acc && rc != 0) begin
            if (!(md && rc == 1)) q.push_back('{d: DATA_W'(rc), c: 1'b1});
            q.push_back('{d: rd, c: 1'b0});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run_valid = 1'b0; tok_ready = 1'b0;
        @(negedge clock);
        chk("rst_run_ready", 64'(run_ready), 64'd0);
        chk("rst_tok_valid", 64'(tok_valid), 64'd0);
        @(posedge clock);
        #1;
        q.delete();
        m_drop  = 1'b0;
        m_total = 0;
        reset   = 1'b0;
    endtask

    bit                 r_rv, r_md, r_tr;
    logic [COUNT_W-1:0] r_rc;
    int                 sel;

    initial begin
        // Reset state
        do_reset();
        do_reset();
        chk("reset_tok_data",  64'(tok_data),  64'd0);
        chk("reset_run_drop",  64'(run_drop),  64'd0);
        chk("reset_tok_total", 64'(tok_total), 64'd0);
        step(0, '0, '0, 0, 1);

        // Full mode, tok_ready=1
        step(1, 32'hDEADBEEF, 8'd3, 0, 1);
        chk("full_cnt_tok", 64'(tok_data), 64'h3);
        step(0, '0, '0, 0, 1);
        chk("full_data_tok", 64'(tok_data), 64'hDEADBEEF);
        step(0, '0, '0, 0, 1);
        chk("full_total", 64'(tok_total), 64'd2);
        step(0, '0, '0, 0, 1);

        // Compact mode, back-to-back acceptance
        do_reset();
        step(1, 32'h11111111, 8'd1, 1, 1);
        chk("cmp_first_data", 64'(tok_data), 64'h11111111);
        step(1, 32'h22222222, 8'd5, 1, 1);
        chk("cmp_count5", 64'(tok_data), 64'h5);
        step(0, '0, '0, 1, 1);
        step(0, '0, '0, 1, 1);
        chk("cmp_total", 64'(tok_total), 64'd3);

        // Zero-count drop followed by a normal run
        do_reset();
        step(1, 32'hAAAA5555, 8'd0, 0, 1);
        chk("zero_drop_pulse", 64'(run_drop), 64'd1);
        step(1, 32'h1, 8'd2, 0, 1);
        chk("zero_drop_clear", 64'(run_drop), 64'd0);
        step(0, '0, '0, 0, 1);
        step(0, '0, '0, 0, 1);
        step(1, 32'h0, 8'd0, 0, 1);
        step(1, 32'h0, 8'd0, 0, 1);
        step(0, '0, '0, 0, 1);
        step(0, '0, '0, 0, 1);

        // Backpressure on a count-255 token
        do_reset();
        step(1, 32'hCAFEF00D, 8'd255, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 32'h9, 8'd4, 0, 0);
        chk("bp_cnt_hold", 64'(tok_data), 64'h000000FF);
        step(0, '0, '0, 0, 1);
        step(0, '0, '0, 0, 1);
        step(0, '0, '0, 0, 1);

        // Saturation of a 2-bit token counter
        do_reset();
        for (int i = 0; i < 5; i++) step(1, DATA_W'(i + 1), 8'd1, 1, 1);
        step(0, '0, '0, 1, 1);
        chk("sat_final", 64'(s_tok_total), 64'd3);
        chk("sat_wide_total", 64'(tok_total), 64'd5);

        // Reset while a count token is pending
        do_reset();
        step(1, 32'h5, 8'd9, 0, 0);
        step(0, '0, '0, 0, 0);
        do_reset();
        chk("midrst_tok_valid", 64'(tok_valid), 64'd0);
        chk("midrst_total",     64'(tok_total), 64'd0);
        step(0, '0, '0, 0, 1);
        step(0, '0, '0, 0, 1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                r_rv = ($urandom_range(0, 3) != 0);
                r_md = ($urandom_range(0, 1) != 0);
                r_tr = ($urandom_range(0, 3) != 0);
                sel  = int'($urandom_range(0, 4));
                case (sel)
                    0:       r_rc = 8'd0;
                    1:       r_rc = 8'd1;
                    2:       r_rc = 8'd255;
                    default: r_rc = COUNT_W'($urandom);
                endcase
                step(r_rv, DATA_W'($urandom), r_rc, r_md, r_tr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
